// File: rtl/row_col_multiplier_if.sv
// Handshake and operand/address bus between row_col_multiplier and its parent.
// The slave modport is the multiplier's view; the master modport is the parent's view.
interface row_col_multiplier_if #(
  parameter int m_len = 2,
  parameter int n_len = 3
);
  logic              start;
  logic [31:0]       a_in;
  logic [31:0]       b_in;
  logic [31:0]       current_element;
  logic              z_ack;
  logic [m_len-1:0]  a_i;
  logic [n_len-1:0]  a_j;
  logic [n_len-1:0]  b_i;
  logic [m_len-1:0]  b_j;
  logic [m_len-1:0]  z_i;
  logic [m_len-1:0]  z_j;
  logic [31:0]       z_out;
  logic              z_stb;
  logic              done;

  modport slave (
    input  start, a_in, b_in, current_element, z_ack,
    output a_i, a_j, b_i, b_j, z_i, z_j, z_out, z_stb, done
  );

  modport master (
    output start, a_in, b_in, current_element, z_ack,
    input  a_i, a_j, b_i, b_j, z_i, z_j, z_out, z_stb, done
  );
endinterface

// File: rtl/row_col_multiplier.sv
// Computes an m x m block of A*B (dot products of length n), one MAC per cycle.
// Define ROW_COL_MUL_ACCUMULATE_EN to add current_element into each written result.
module row_col_multiplier #(
  parameter int n     = 8,
  parameter int m     = 4,
  parameter int m_len = $clog2(m),
  parameter int n_len = $clog2(n)
) (
  input  logic                 clk,
  input  logic                 rst,
  row_col_multiplier_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  localparam logic [n_len-1:0] k_last = n_len'(n - 1);
  localparam logic [m_len-1:0] blk_last = m_len'(m - 1);

  state_t            state;
  logic [m_len-1:0]  row;
  logic [m_len-1:0]  col;
  logic [n_len-1:0]  k;
  logic [31:0]       acc;
  logic [31:0]       z_out;
  logic              z_stb;
  logic              done;
  logic [31:0]       prod;
  logic [31:0]       base;

  assign prod = bus.a_in * bus.b_in;

`ifdef ROW_COL_MUL_ACCUMULATE_EN
  assign base = bus.current_element;
`else
  logic unused_current_element;
  assign base = '0;
  assign unused_current_element = ^bus.current_element;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      k     <= '0;
      acc   <= '0;
      z_out <= '0;
      z_stb <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state <= CALC;
            row   <= '0;
            col   <= '0;
            k     <= '0;
            acc   <= '0;
            done  <= 1'b0;
          end
        end
        CALC: begin
          // Final term is folded straight into z_out so the write is ready n cycles after entry.
          if (k == k_last) begin
            z_out <= base + acc + prod;
            z_stb <= 1'b1;
            state <= WRITE;
          end else begin
            acc <= acc + prod;
            k   <= k + 1'b1;
          end
        end
        WRITE: begin
          if (bus.z_ack) begin
            z_stb <= 1'b0;
            if (row == blk_last && col == blk_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              if (col == blk_last) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              k     <= '0;
              acc   <= '0;
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_i   = row;
  assign bus.z_i   = row;
  assign bus.b_j   = col;
  assign bus.z_j   = col;
  assign bus.a_j   = k;
  assign bus.b_i   = k;
  assign bus.z_out = z_out;
  assign bus.z_stb = z_stb;
  assign bus.done  = done;
endmodule

// File: tb/tb_row_col_multiplier.sv
// Scoreboard bench for row_col_multiplier at n=4, m=2: directed matrices with
// hand-computed block results, a modelled parent memory and a decoupled monitor.
module tb_row_col_multiplier;
  localparam int N = 4;
  localparam int M = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_col_multiplier_if #(.m_len(1), .n_len(2)) bus ();

  row_col_multiplier #(.n(N), .m(M), .m_len(1), .n_len(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] amat [M][N];
  logic [31:0] bmat [N][M];
  logic [31:0] ce;

  assign bus.a_in            = amat[bus.a_i][bus.a_j];
  assign bus.b_in            = bmat[bus.b_i][bus.b_j];
  assign bus.current_element = ce;

  typedef struct {
    logic [31:0] r;
    logic [31:0] c;
    logic [31:0] z;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   passed = 0;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  logic ack_prev = 1'b0;
  logic prev_stb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Parent acknowledge: waits ack_delay cycles of z_stb, then acks for one cycle.
  always @(negedge clk) begin
    if (ack_prev) chk("stb_drop_after_ack", {31'b0, bus.z_stb}, 32'd0);
    if (bus.z_stb) begin
      if (wait_cnt >= ack_delay) bus.z_ack = 1'b1;
      else begin
        bus.z_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.z_ack = 1'b0;
      wait_cnt = 0;
    end
    ack_prev = bus.z_ack && bus.z_stb;
  end

  always @(negedge clk) begin
    if (bus.z_stb && !prev_stb) begin
      if (sb.size() == 0) begin
        chk("unexpected_stb", {31'b0, bus.z_stb}, 32'd0);
      end else begin
        cur = sb.pop_front();
        chk("z_out", bus.z_out, cur.z);
        chk("z_i", {31'b0, bus.z_i}, cur.r);
        chk("z_j", {31'b0, bus.z_j}, cur.c);
        chk("a_i", {31'b0, bus.a_i}, cur.r);
        chk("b_j", {31'b0, bus.b_j}, cur.c);
      end
    end else if (bus.z_stb) begin
      chk("hold_z_out", bus.z_out, cur.z);
      chk("hold_z_i", {31'b0, bus.z_i}, cur.r);
      chk("hold_z_j", {31'b0, bus.z_j}, cur.c);
    end
    prev_stb = bus.z_stb;
  end

  task automatic push4(input logic [31:0] z00, input logic [31:0] z01,
                       input logic [31:0] z10, input logic [31:0] z11);
    sb.push_back('{32'd0, 32'd0, z00});
    sb.push_back('{32'd0, 32'd1, z01});
    sb.push_back('{32'd1, 32'd0, z10});
    sb.push_back('{32'd1, 32'd1, z11});
  endtask

  task automatic fill(input logic [31:0] av, input logic [31:0] bv);
    for (int r = 0; r < M; r++)
      for (int k = 0; k < N; k++) amat[r][k] = av;
    for (int k = 0; k < N; k++)
      for (int c = 0; c < M; c++) bmat[k][c] = bv;
  endtask

  task automatic fill_identity();
    for (int r = 0; r < M; r++)
      for (int k = 0; k < N; k++) amat[r][k] = (k == r) ? 32'd1 : 32'd0;
    for (int k = 0; k < N; k++)
      for (int c = 0; c < M; c++) bmat[k][c] = 32'(10 * k + c);
  endtask

  task automatic run(input int start_cycles);
    int budget;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (start_cycles) @(negedge clk);
    chk("done_low_after_start", {31'b0, bus.done}, 32'd0);
    bus.start = 1'b0;
    budget = 0;
    while (!bus.done && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    chk("done", {31'b0, bus.done}, 32'd1);
    chk("scoreboard_drained", sb.size(), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("done_held", {31'b0, bus.done}, 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_a_i"},   {31'b0, bus.a_i}, 32'd0);
    chk({tag, "_a_j"},   {30'b0, bus.a_j}, 32'd0);
    chk({tag, "_b_i"},   {30'b0, bus.b_i}, 32'd0);
    chk({tag, "_b_j"},   {31'b0, bus.b_j}, 32'd0);
    chk({tag, "_z_out"}, bus.z_out, 32'd0);
    chk({tag, "_z_stb"}, {31'b0, bus.z_stb}, 32'd0);
    chk({tag, "_done"},  {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    ce = 32'd0;
    fill(32'd1, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // All ones, single-cycle ack: every dot product is 4.
    ack_delay = 0;
    push4(32'd4, 32'd4, 32'd4, 32'd4);
    run(1);

    // Identity A against B[k][c]=10k+c; start held into CALC must be ignored.
    fill_identity();
    ack_delay = 2;
    push4(32'd0, 32'd1, 32'd10, 32'd11);
    run(3);

    // Existing element 10 with dot 4; ack held off for 5 cycles.
    fill(32'd1, 32'd1);
    ce = 32'd10;
    ack_delay = 5;
`ifdef ROW_COL_MUL_ACCUMULATE_EN
    push4(32'd14, 32'd14, 32'd14, 32'd14);
`else
    push4(32'd4, 32'd4, 32'd4, 32'd4);
`endif
    run(1);
    ce = 32'd0;

    // 0x10000 squared wraps to zero.
    ack_delay = 0;
    fill(32'h0001_0000, 32'h0001_0000);
    push4(32'd0, 32'd0, 32'd0, 32'd0);
    run(1);

    // (-1)*3 summed over four terms is -12.
    ack_delay = 1;
    fill(32'hFFFF_FFFF, 32'd3);
    push4(32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'hFFFF_FFF4);
    run(1);

    // Abort in the second CALC cycle; no writes may follow until restarted.
    fill_identity();
    ack_delay = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_abort_a_j", {30'b0, bus.a_j}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("abort");
    repeat (15) @(negedge clk);
    chk("abort_stays_idle_stb", {31'b0, bus.z_stb}, 32'd0);
    push4(32'd0, 32'd1, 32'd10, 32'd11);
    run(1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/row_col_multiplier.md
ROW_COL_MULTIPLIER -- requirements
Module: row_col_multiplier

Interface
REQ-001 Parameter n, default 8: full matrix dimension; dot-product length.
REQ-002 Parameter m, default 4: output block dimension; m >= 2, n >= 2, n an integer multiple of m.
REQ-003 Parameter m_len, default $clog2(m): width of block-local indices; parameter n_len, default $clog2(n): width of full-range indices.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin block computation when sampled high in IDLE or DONE.
REQ-007 a_in  input  32  operand A[a_i][a_j], combinationally supplied by parent from current a_i/a_j.
REQ-008 b_in  input  32  operand B[b_i][b_j], combinationally supplied from current b_i/b_j.
REQ-009 current_element  input  32  existing R value at z_i/z_j, combinational.
REQ-010 z_ack  input  1  parent acknowledge of result write.
REQ-011 a_i  output  m_len  block-local A row; a_j  output  n_len  A column.
REQ-012 b_i  output  n_len  B row; b_j  output  m_len  block-local B column.
REQ-013 z_i, z_j  output  m_len each  block-local result row/column.
REQ-014 z_out  output  32  result value; z_stb  output  1  result valid; done  output  1  block complete.

Function
REQ-015 Block computes, for every (r,c) in 0..m-1 x 0..m-1, dot(r,c) = sum over k=0..n-1 of a_in*b_in with a_i=r, a_j=k, b_i=k, b_j=c.
REQ-016 Arithmetic: 32-bit two's-complement; product and sum keep low 32 bits (wrap modulo 2^32), no saturation, no flags.
REQ-017 Elements visited row-major: (0,0),(0,1)..(0,m-1),(1,0)..(m-1,m-1).
REQ-018 All address outputs registered; z_i always equals a_i and z_j always equals b_j.
REQ-019 States: IDLE, CALC, WRITE, DONE.
REQ-020 IDLE: start=1 -> CALC, indices (0,0), k=0, accumulator 0, done=0.
REQ-021 CALC: one MAC per cycle, acc += a_in*b_in using operands present that cycle; k increments; exactly n cycles per element.
REQ-022 On the CALC cycle with k=n-1: z_out <= current_element + acc + a_in*b_in, z_stb <= 1, -> WRITE.
REQ-023 WRITE: z_stb and z_out held stable until z_ack=1 sampled; then z_stb <= 0, next element's addresses loaded, k=0, acc=0, -> CALC; after last element -> DONE instead.
REQ-024 Minimum latency per element n+2 cycles with single-cycle ack; ack may be delayed indefinitely.
REQ-025 z_ack outside WRITE ignored; z_stb never asserted outside WRITE.
REQ-026 DONE: done=1 held; start=1 restarts as from IDLE (done drops next cycle); start ignored in CALC/WRITE.
REQ-027 Exactly m*m z_stb pulses-with-ack per run; no element skipped or repeated.

Reset
REQ-028 rst=1 at a clock edge: state IDLE, all address outputs 0, z_out=0, z_stb=0, done=0, accumulator/counters 0; takes priority over start and z_ack.
REQ-029 rst mid-CALC or mid-WRITE aborts the run; no further z_stb until a new start.

Configuration
REQ-030 Macro ROW_COL_MUL_ACCUMULATE_EN: defined -> z_out = current_element + dot (REQ-022); undefined -> z_out = dot, current_element ignored.

Verification
REQ-031 n=4,m=2, A rows all 1, B all 1, z_ack one cycle after z_stb, macro defined, current_element=0 -> four writes (0,0),(0,1),(1,0),(1,1), each z_out=4, then done=1.
REQ-032 A=identity, B[k][c]=10*k+c -> z_out at (r,c) equals 10*r+c.
REQ-033 current_element=10, dot=4 -> z_out=14 with macro, 4 without.
REQ-034 Hold z_ack low 5 cycles in WRITE -> z_stb stays 1, z_out and z_i/z_j unchanged, then advance one cycle after ack.
REQ-035 a_in=b_in=0x00010000 all k -> z_out=0 (wrap); a_in=-1,b_in=3,n=4 -> z_out=-12.
REQ-036 rst asserted during second CALC cycle -> next cycle all outputs 0, done=0; start reissued -> full correct run.
